operand_fetch: RTL and testbench

// Requester/writer side of the 2-phase register-file port. Accepts decoded register specifiers, issues

---
 rtl/operand_fetch_if.sv | 59 +++++
 rtl/operand_fetch.sv | 133 +++++++++++++
 tb/tb_operand_fetch.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/operand_fetch_if.sv
// Bundle between operand_fetch and its neighbours: decode requests, operand
// output, writeback requests and the two-phase register-file port.
//   dec_*  : decode request (valid/ready) with rs1/rs2/rd/ctrl
//   op_*   : operand FIFO head (valid/ready) with values, rd, ctrl
//   wb_*   : writeback request (valid/ready) with rd and data
//   rf_*   : register-file read indices/data and write index/data/enable
// master = operand_fetch side, slave = surrounding pipeline and regfile.
interface operand_fetch_if #(
  parameter int unsigned CTRL_W = 8
);
  logic              dec_valid;
  logic              dec_ready;
  logic [4:0]        dec_rs1;
  logic [4:0]        dec_rs2;
  logic [4:0]        dec_rd;
  logic [CTRL_W-1:0] dec_ctrl;

  logic              op_valid;
  logic              op_ready;
  logic [31:0]       op_rs1_v;
  logic [31:0]       op_rs2_v;
  logic [4:0]        op_rd;
  logic [CTRL_W-1:0] op_ctrl;

  logic              wb_valid;
  logic              wb_ready;
  logic [4:0]        wb_rd;
  logic [31:0]       wb_v;

  logic [4:0]        rf_rs1;
  logic [4:0]        rf_rs2;
  logic [4:0]        rf_rd;
  logic [31:0]       rf_rd_v;
  logic              rf_we;
  logic [31:0]       rf_rs1_v;
  logic [31:0]       rf_rs2_v;

  modport master (
    input  dec_valid, dec_rs1, dec_rs2, dec_rd, dec_ctrl,
    output dec_ready,
    output op_valid, op_rs1_v, op_rs2_v, op_rd, op_ctrl,
    input  op_ready,
    input  wb_valid, wb_rd, wb_v,
    output wb_ready,
    output rf_rs1, rf_rs2, rf_rd, rf_rd_v, rf_we,
    input  rf_rs1_v, rf_rs2_v
  );

  modport slave (
    output dec_valid, dec_rs1, dec_rs2, dec_rd, dec_ctrl,
    input  dec_ready,
    input  op_valid, op_rs1_v, op_rs2_v, op_rd, op_ctrl,
    output op_ready,
    output wb_valid, wb_rd, wb_v,
    input  wb_ready,
    input  rf_rs1, rf_rs2, rf_rd, rf_rd_v, rf_we,
    output rf_rs1_v, rf_rs2_v
  );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch: issues decode reads on the two-phase register-file port,
// returns operand pairs in order through a small FIFO, owns the write port
// and bypasses same-slot writeback data into reads.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : operand_fetch_if.master (dec_*, op_*, wb_*, rf_*)
module operand_fetch #(
  parameter int unsigned CTRL_W    = 8,
  parameter int unsigned OUT_DEPTH = 2
) (
  input logic              clk,
  input logic              rst_n,
  operand_fetch_if.master  bus
);
  localparam int unsigned PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(OUT_DEPTH + 1);

  typedef struct packed {
    logic [31:0]       rs1_v;
    logic [31:0]       rs2_v;
    logic [4:0]        rd;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  logic              ph_q, ph_d;
  logic              inflight_q, inflight_d;
  logic [4:0]        rs1_q, rs2_q, rd_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic              byp1_q, byp2_q;
  logic [31:0]       byp_v_q;
  logic [4:0]        wrd_q;
  logic [31:0]       wv_q;
  entry_t            mem_q [OUT_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic   rd_acc, wb_acc, wb_hit, capture, pop;
  entry_t cap_e;

  // Slot is the ph==0 cycle; reads are credited against FIFO space plus the read in flight.
  assign bus.wb_ready  = ~ph_q;
  assign bus.dec_ready = ~ph_q && ((32'(cnt_q) + 32'(inflight_q)) < OUT_DEPTH);

  assign rd_acc  = bus.dec_valid && bus.dec_ready;
  assign wb_acc  = bus.wb_valid && bus.wb_ready;
  assign wb_hit  = wb_acc && (bus.wb_rd != 5'd0);
  // Read data is on the port during the slot after the accept; capture at its closing edge.
  assign capture = inflight_q && ~ph_q;
  assign pop     = bus.op_valid && bus.op_ready;

  // Port indices: live from decode/writeback on accept, otherwise held.
  assign bus.rf_rs1  = rd_acc ? bus.dec_rs1 : rs1_q;
  assign bus.rf_rs2  = rd_acc ? bus.dec_rs2 : rs2_q;
  assign bus.rf_we   = wb_hit;
  assign bus.rf_rd   = wb_acc ? bus.wb_rd : wrd_q;
  assign bus.rf_rd_v = wb_acc ? bus.wb_v  : wv_q;

  // Captured entry: x0 forced to zero, then same-slot bypass, then port data.
  always_comb begin
    cap_e.rs1_v = (rs1_q == 5'd0) ? 32'h0 : (byp1_q ? byp_v_q : bus.rf_rs1_v);
    cap_e.rs2_v = (rs2_q == 5'd0) ? 32'h0 : (byp2_q ? byp_v_q : bus.rf_rs2_v);
    cap_e.rd    = rd_q;
    cap_e.ctrl  = ctrl_q;
  end

  assign bus.op_valid = (cnt_q != CNT_W'(0));
  assign bus.op_rs1_v = mem_q[rd_ptr_q].rs1_v;
  assign bus.op_rs2_v = mem_q[rd_ptr_q].rs2_v;
  assign bus.op_rd    = mem_q[rd_ptr_q].rd;
  assign bus.op_ctrl  = mem_q[rd_ptr_q].ctrl;

  // Next-state for phase, in-flight flag and FIFO bookkeeping.
  always_comb begin
    ph_d       = ~ph_q;
    inflight_d = inflight_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    if (capture) inflight_d = 1'b0;
    if (rd_acc)  inflight_d = 1'b1;
    if (capture) wr_ptr_d = (wr_ptr_q == PTR_W'(OUT_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    if (pop)     rd_ptr_d = (rd_ptr_q == PTR_W'(OUT_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    cnt_d = cnt_q + CNT_W'(capture) - CNT_W'(pop);
  end

  // State and FIFO storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q       <= 1'b1;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      ph_q       <= ph_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      if (capture) mem_q[wr_ptr_q] <= cap_e;
    end
  end

  // Latched request copies and per-source bypass flags (writeback is older than a same-slot read).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      ctrl_q  <= '0;
      byp1_q  <= 1'b0;
      byp2_q  <= 1'b0;
      byp_v_q <= '0;
      wrd_q   <= '0;
      wv_q    <= '0;
    end else begin
      if (rd_acc) begin
        rs1_q   <= bus.dec_rs1;
        rs2_q   <= bus.dec_rs2;
        rd_q    <= bus.dec_rd;
        ctrl_q  <= bus.dec_ctrl;
        byp1_q  <= wb_hit && (bus.wb_rd == bus.dec_rs1);
        byp2_q  <= wb_hit && (bus.wb_rd == bus.dec_rs2);
        byp_v_q <= bus.wb_v;
      end
      if (wb_acc) begin
        wrd_q <= bus.wb_rd;
        wv_q  <= bus.wb_v;
      end
    end
  end
endmodule

// File: tb/tb_operand_fetch.sv
// Testbench for operand_fetch: regfile model on the rf_* port, scoreboard of
// expected operand pairs pushed at read accept and popped at FIFO output.
module tb_operand_fetch;
  localparam int unsigned CTRL_W = 8;

  logic clk;
  logic rst_n;

  operand_fetch_if #(.CTRL_W(CTRL_W)) bus ();

  operand_fetch #(.CTRL_W(CTRL_W), .OUT_DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]       rs1_v;
    logic [31:0]       rs2_v;
    logic [4:0]        rd;
    logic [CTRL_W-1:0] ctrl;
  } exp_t;

  exp_t        exp_q [$];
  int          n_total = 0;
  int          n_bad   = 0;
  int          acc_cnt = 0;
  logic [31:0] regs [32];

  logic        rd_pend, wr_pend;
  logic [4:0]  rd_i1, rd_i2, wr_idx;
  logic [31:0] wr_val;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_src(input logic [4:0] idx);
    if (idx == 5'd0) return 32'h0;
    if (bus.wb_valid && bus.wb_ready && bus.wb_rd != 5'd0 && bus.wb_rd == idx) return bus.wb_v;
    return regs[idx];
  endfunction

  // Regfile model: reads sampled at the accept edge and held, writes committed at the edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'hA5A5_0000 | 32'(i);
      bus.rf_rs1_v <= 32'h0;
      bus.rf_rs2_v <= 32'h0;
    end else begin
      if (rd_pend) begin
        bus.rf_rs1_v <= regs[rd_i1];
        bus.rf_rs2_v <= regs[rd_i2];
      end
      if (wr_pend) regs[wr_idx] <= wr_val;
    end
  end

  // Monitor: handshakes that will complete at the coming posedge.
  always @(negedge clk) begin
    exp_t e;
    rd_pend = 1'b0;
    wr_pend = 1'b0;
    if (rst_n) begin
      if (bus.dec_valid && bus.dec_ready) begin
        chk("rf_rs1_idx", 32'(bus.rf_rs1), 32'(bus.dec_rs1));
        chk("rf_rs2_idx", 32'(bus.rf_rs2), 32'(bus.dec_rs2));
        e.rs1_v = model_src(bus.dec_rs1);
        e.rs2_v = model_src(bus.dec_rs2);
        e.rd    = bus.dec_rd;
        e.ctrl  = bus.dec_ctrl;
        exp_q.push_back(e);
        acc_cnt++;
        rd_pend = 1'b1;
        rd_i1   = bus.rf_rs1;
        rd_i2   = bus.rf_rs2;
      end
      if (bus.wb_valid && bus.wb_ready) begin
        chk("rf_we", 32'(bus.rf_we), 32'(bus.wb_rd != 5'd0));
        if (bus.wb_rd != 5'd0) begin
          chk("rf_rd", 32'(bus.rf_rd), 32'(bus.wb_rd));
          chk("rf_rd_v", bus.rf_rd_v, bus.wb_v);
        end
      end else begin
        chk("rf_we_idle", 32'(bus.rf_we), 32'h0);
      end
      wr_pend = bus.rf_we;
      wr_idx  = bus.rf_rd;
      wr_val  = bus.rf_rd_v;
      if (bus.op_valid && bus.op_ready) begin
        chk("sb_nonempty", 32'(exp_q.size() > 0), 32'h1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("op_rs1_v", bus.op_rs1_v, e.rs1_v);
          chk("op_rs2_v", bus.op_rs2_v, e.rs2_v);
          chk("op_rd", 32'(bus.op_rd), 32'(e.rd));
          chk("op_ctrl", 32'(bus.op_ctrl), 32'(e.ctrl));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.dec_valid = 1'b0;
    bus.dec_rs1   = 5'd0;
    bus.dec_rs2   = 5'd0;
    bus.dec_rd    = 5'd0;
    bus.dec_ctrl  = '0;
    bus.wb_valid  = 1'b0;
    bus.wb_rd     = 5'd0;
    bus.wb_v      = 32'h0;
  endtask

  // Wait (bounded) for a slot cycle in which a read can also be accepted.
  task automatic slot_wait();
    int n = 0;
    while (!(bus.wb_ready && bus.dec_ready) && n < 20) begin
      step();
      n++;
    end
    chk("slot_wait", 32'(bus.wb_ready && bus.dec_ready), 32'h1);
  endtask

  // Offer one read and hold it until accepted (bounded).
  task automatic issue(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                       input logic [CTRL_W-1:0] ctrl);
    int base = acc_cnt;
    int n = 0;
    bus.dec_rs1 = r1; bus.dec_rs2 = r2; bus.dec_rd = rd; bus.dec_ctrl = ctrl;
    bus.dec_valid = 1'b1;
    while (acc_cnt == base && n < 20) begin
      step();
      n++;
    end
    bus.dec_valid = 1'b0;
    chk("issue_accepted", 32'(acc_cnt - base), 32'h1);
  endtask

  task automatic drain();
    int n = 0;
    bus.op_ready = 1'b1;
    while ((exp_q.size() > 0 || bus.op_valid) && n < 50) begin
      step();
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [CTRL_W-1:0] seq;
    rst_n = 1'b0;
    clear_inputs();
    bus.op_ready = 1'b0;
    repeat (3) @(posedge clk);

    // Reset state
    @(negedge clk);
    chk("rst_dec_ready", 32'(bus.dec_ready), 32'h0);
    chk("rst_wb_ready", 32'(bus.wb_ready), 32'h0);
    chk("rst_op_valid", 32'(bus.op_valid), 32'h0);
    chk("rst_op_rs1_v", bus.op_rs1_v, 32'h0);
    chk("rst_rf_we", 32'(bus.rf_we), 32'h0);
    chk("rst_rf_rs1", 32'(bus.rf_rs1), 32'h0);
    chk("rst_rf_rd_v", bus.rf_rd_v, 32'h0);

    // Test 1: phase after release
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t1_dec_ready", 32'(bus.dec_ready), 32'(c % 2));
      chk("t1_wb_ready", 32'(bus.wb_ready), 32'(c % 2));
      step();
    end

    // Test 2: write x5 then read it in the next slot
    bus.op_ready = 1'b1;
    slot_wait();
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd5; bus.wb_v = 32'hDEADBEEF;
    step();
    clear_inputs();
    issue(5'd5, 5'd0, 5'd3, 8'h11);
    @(negedge clk);
    chk("t2_valid_n1", 32'(bus.op_valid), 32'h0);
    step();
    @(negedge clk);
    chk("t2_valid_n2", 32'(bus.op_valid), 32'h0);
    step();
    @(negedge clk);
    chk("t2_valid_n3", 32'(bus.op_valid), 32'h1);
    chk("t2_rs1", bus.op_rs1_v, 32'hDEADBEEF);
    step();
    drain();

    // Test 3: same-slot write and read of x7
    slot_wait();
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd7; bus.wb_v = 32'h12345678;
    bus.dec_valid = 1'b1; bus.dec_rs1 = 5'd7; bus.dec_rs2 = 5'd7; bus.dec_rd = 5'd9; bus.dec_ctrl = 8'h22;
    step();
    clear_inputs();
    drain();

    // Test 4: write to x0 is dropped, x0 reads as zero
    slot_wait();
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd0; bus.wb_v = 32'hFFFFFFFF;
    step();
    clear_inputs();
    issue(5'd0, 5'd0, 5'd1, 8'h33);
    drain();

    // Test 5: back-pressure limits accepts to FIFO depth
    bus.op_ready = 1'b0;
    base = acc_cnt;
    issue(5'd1, 5'd2, 5'd4, 8'h01);
    issue(5'd3, 5'd4, 5'd5, 8'h02);
    bus.dec_rs1 = 5'd5; bus.dec_rs2 = 5'd6; bus.dec_rd = 5'd6; bus.dec_ctrl = 8'h03;
    bus.dec_valid = 1'b1;
    repeat (8) step();
    chk("t5_accepts_stalled", 32'(acc_cnt - base), 32'h2);
    chk("t5_head_valid", 32'(bus.op_valid), 32'h1);
    chk("t5_head_ctrl", 32'(bus.op_ctrl), 32'h01);
    bus.op_ready = 1'b1;
    for (int n = 0; n < 20 && acc_cnt - base < 3; n++) step();
    bus.dec_valid = 1'b0;
    chk("t5_accepts_final", 32'(acc_cnt - base), 32'h3);
    drain();

    // Test 6: reset right after an accept discards the read
    issue(5'd2, 5'd3, 5'd7, 8'h44);
    rst_n = 1'b0;
    step();
    exp_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_wb_ready_ph1", 32'(bus.wb_ready), 32'h0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("t6_op_valid", 32'(bus.op_valid), 32'h0);
    end
    step();

    // Random mix with small index range to hit bypass paths
    seq = 8'h80;
    for (int it = 0; it < 200; it++) begin
      bus.op_ready  = ($urandom_range(0, 3) != 0);
      bus.wb_valid  = $urandom_range(0, 1) == 1;
      bus.wb_rd     = 5'($urandom_range(0, 7));
      bus.wb_v      = $urandom;
      bus.dec_valid = $urandom_range(0, 1) == 1;
      bus.dec_rs1   = 5'($urandom_range(0, 7));
      bus.dec_rs2   = 5'($urandom_range(0, 7));
      bus.dec_rd    = 5'($urandom_range(0, 31));
      bus.dec_ctrl  = seq;
      step();
      seq = seq + 8'd1;
    end
    clear_inputs();
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
